// File: rtl/tictactoe_pkg.sv
// ----------------------------------------------------------------------------
// tictactoe_pkg: shared FSM state, rejection code and winner encodings.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tictactoe_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_MOVE = 3'd1,
        CHECK     = 3'd2,
        JUDGE     = 3'd3,
        DONE      = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_ERASED = 2'b01,
        ERR_COUNT  = 2'b10,
        ERR_PLANE  = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_A    = 2'b01,
        WIN_B    = 2'b10
    } winner_e;

endpackage

`default_nettype wire

// File: rtl/board_move_checker.sv
// ----------------------------------------------------------------------------
// board_move_checker: combinational legality check of a proposed full board.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module board_move_checker
    import tictactoe_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N-1:0] board_a,
    input  logic [N-1:0] board_b,
    input  logic [N-1:0] prop_a,
    input  logic [N-1:0] prop_b,
    input  logic         mover_is_a,
    output logic         ok,
    output logic [1:0]   err_code
);

    localparam logic [2*N-1:0] c_one = {{(2*N-1){1'b0}}, 1'b1};

    logic [N-1:0]   w_new_a;
    logic [N-1:0]   w_new_b;
    logic [2*N-1:0] w_new_all;
    logic           w_erased;
    logic           w_one_new;
    logic           w_plane_bad;

    assign w_new_a   = prop_a & ~board_a;
    assign w_new_b   = prop_b & ~board_b;
    assign w_new_all = {w_new_b, w_new_a};
    assign w_erased  = ((board_a & ~prop_a) != '0) || ((board_b & ~prop_b) != '0);

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_one_new = (w_new_all != '0) && ((w_new_all & (w_new_all - c_one)) == '0);

    assign w_plane_bad = (mover_is_a ? (w_new_b != '0) : (w_new_a != '0))
                       || ((prop_a & prop_b) != '0);

    always_comb begin
        ok       = 1'b0;
        err_code = ERR_NONE;
        if (w_erased) begin
            err_code = ERR_ERASED;
        end else if (!w_one_new) begin
            err_code = ERR_COUNT;
        end else if (w_plane_bad) begin
            err_code = ERR_PLANE;
        end else begin
            ok = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/board_commit_arbiter.sv
// ----------------------------------------------------------------------------
// board_commit_arbiter: arbitrates local/remote moves and commits legal boards.
// Optional MOVE_TIMEOUT_EN adds a remote-move timeout. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module board_commit_arbiter
    import tictactoe_pkg::*;
#(
    parameter int ROWS           = 3,
    parameter int COLS           = 3,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 local_is_a,
    input  logic                 loc_valid,
    output logic                 loc_ready,
    input  logic [ROWS*COLS-1:0] loc_board_a,
    input  logic [ROWS*COLS-1:0] loc_board_b,
    input  logic                 rem_valid,
    output logic                 rem_ready,
    input  logic [ROWS*COLS-1:0] rem_board_a,
    input  logic [ROWS*COLS-1:0] rem_board_b,
    output logic [ROWS*COLS-1:0] board_a,
    output logic [ROWS*COLS-1:0] board_b,
    output logic                 judge_req,
    input  logic                 judge_ready,
    input  logic                 judge_end,
    input  logic                 judge_win_a,
    input  logic                 judge_win_b,
    output logic                 turn_a,
    output logic                 move_error,
    output logic [1:0]           err_code,
    output logic                 game_over,
    output logic [1:0]           winner,
    output logic                 timeout
);

    localparam int N   = ROWS * COLS;
    localparam int MCW = $clog2(N + 1);

    state_e         r_state;
    state_e         w_next_state;
    logic [N-1:0]   r_board_a;
    logic [N-1:0]   r_board_b;
    logic [N-1:0]   r_prop_a;
    logic [N-1:0]   r_prop_b;
    logic           r_turn_a;
    logic           r_local_is_a;
    logic           r_move_error;
    logic           r_timeout;
    logic           r_game_over;
    logic [1:0]     r_err_code;
    logic [1:0]     r_winner;
    logic [MCW-1:0] r_move_cnt;

    logic           w_wait;
    logic           w_mover_local;
    logic           w_loc_xfer;
    logic           w_rem_xfer;
    logic           w_last_move;
    logic           w_to_hit;
    logic           w_ok;
    logic [1:0]     w_err_code;

    assign w_wait        = (r_state == WAIT_MOVE);
    assign w_mover_local = (r_turn_a == r_local_is_a);
    assign loc_ready     = w_wait && w_mover_local;
    assign rem_ready     = w_wait && !w_mover_local;
    assign w_loc_xfer    = loc_valid && loc_ready;
    assign w_rem_xfer    = rem_valid && rem_ready;
    assign w_last_move   = (r_move_cnt == MCW'(N));

    board_move_checker #(.N(N)) u_checker (
        .board_a    (r_board_a),
        .board_b    (r_board_b),
        .prop_a     (r_prop_a),
        .prop_b     (r_prop_b),
        .mover_is_a (r_turn_a),
        .ok         (w_ok),
        .err_code   (w_err_code)
    );

`ifdef MOVE_TIMEOUT_EN
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TCW-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (!reset || start || !rem_ready) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TCW'(1);
        end
    end

    assign w_to_hit = rem_ready && (r_to_cnt == TCW'(TIMEOUT_CYCLES - 1));
`else
    assign w_to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      w_next_state = IDLE;
            // A proposal arriving on the final cycle still beats the timeout.
            WAIT_MOVE: begin
                if (w_loc_xfer || w_rem_xfer) begin
                    w_next_state = CHECK;
                end else if (w_to_hit) begin
                    w_next_state = DONE;
                end
            end
            CHECK:     w_next_state = w_ok ? JUDGE : WAIT_MOVE;
            JUDGE: begin
                if (judge_ready) begin
                    w_next_state = (judge_end || w_last_move) ? DONE : WAIT_MOVE;
                end
            end
            DONE:      w_next_state = DONE;
            default:   w_next_state = IDLE;
        endcase
        if (start) begin
            w_next_state = WAIT_MOVE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_board_a    <= '0;
            r_board_b    <= '0;
            r_prop_a     <= '0;
            r_prop_b     <= '0;
            r_turn_a     <= 1'b1;
            r_local_is_a <= 1'b0;
            r_move_error <= 1'b0;
            r_timeout    <= 1'b0;
            r_game_over  <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_winner     <= WIN_NONE;
            r_move_cnt   <= '0;
        end else begin
            r_move_error <= 1'b0;
            r_timeout    <= 1'b0;
            if (start) begin
                r_board_a    <= '0;
                r_board_b    <= '0;
                r_turn_a     <= 1'b1;
                r_local_is_a <= local_is_a;
                r_game_over  <= 1'b0;
                r_winner     <= WIN_NONE;
                r_move_cnt   <= '0;
            end else begin
                case (r_state)
                    WAIT_MOVE: begin
                        if (w_loc_xfer) begin
                            r_prop_a <= loc_board_a;
                            r_prop_b <= loc_board_b;
                        end else if (w_rem_xfer) begin
                            r_prop_a <= rem_board_a;
                            r_prop_b <= rem_board_b;
                        end else if (w_to_hit) begin
                            r_timeout   <= 1'b1;
                            r_game_over <= 1'b1;
                            r_winner    <= r_local_is_a ? WIN_A : WIN_B;
                        end
                    end
                    CHECK: begin
                        if (w_ok) begin
                            r_board_a  <= r_prop_a;
                            r_board_b  <= r_prop_b;
                            r_move_cnt <= r_move_cnt + MCW'(1);
                        end else begin
                            r_move_error <= 1'b1;
                            r_err_code   <= w_err_code;
                        end
                    end
                    JUDGE: begin
                        if (judge_ready) begin
                            if (judge_end) begin
                                r_game_over <= 1'b1;
                                r_winner    <= {judge_win_b, judge_win_a};
                            end else if (w_last_move) begin
                                r_game_over <= 1'b1;
                                r_winner    <= WIN_NONE;
                            end else begin
                                r_turn_a <= ~r_turn_a;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign board_a    = r_board_a;
    assign board_b    = r_board_b;
    assign judge_req  = (r_state == JUDGE);
    assign turn_a     = r_turn_a;
    assign move_error = r_move_error;
    assign err_code   = r_err_code;
    assign game_over  = r_game_over;
    assign winner     = r_winner;
    assign timeout    = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_board_commit_arbiter.sv
// ----------------------------------------------------------------------------
// tb_board_commit_arbiter: randomized game play against a rule-level model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_board_commit_arbiter;

    localparam int ROWS = 3;
    localparam int COLS = 3;
    localparam int N    = ROWS * COLS;
    localparam int TO   = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         local_is_a = 1'b0;
    logic         loc_valid = 1'b0;
    logic         rem_valid = 1'b0;
    logic [N-1:0] loc_board_a = '0;
    logic [N-1:0] loc_board_b = '0;
    logic [N-1:0] rem_board_a = '0;
    logic [N-1:0] rem_board_b = '0;
    logic         judge_ready = 1'b0;
    logic         judge_end = 1'b0;
    logic         judge_win_a = 1'b0;
    logic         judge_win_b = 1'b0;
    logic         loc_ready, rem_ready, judge_req, turn_a, move_error;
    logic         game_over, timeout;
    logic [1:0]   err_code, winner;
    logic [N-1:0] board_a, board_b;

    board_commit_arbiter #(.ROWS(ROWS), .COLS(COLS), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .local_is_a(local_is_a),
        .loc_valid(loc_valid), .loc_ready(loc_ready),
        .loc_board_a(loc_board_a), .loc_board_b(loc_board_b),
        .rem_valid(rem_valid), .rem_ready(rem_ready),
        .rem_board_a(rem_board_a), .rem_board_b(rem_board_b),
        .board_a(board_a), .board_b(board_b),
        .judge_req(judge_req), .judge_ready(judge_ready),
        .judge_end(judge_end), .judge_win_a(judge_win_a), .judge_win_b(judge_win_b),
        .turn_a(turn_a), .move_error(move_error), .err_code(err_code),
        .game_over(game_over), .winner(winner), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model of the game as seen from outside.
    logic [N-1:0] m_a, m_b;
    logic         m_turn, m_local, m_over;
    logic [1:0]   m_win, m_errc;
    int           m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] model_err(input logic [N-1:0] ca, input logic [N-1:0] cb,
                                             input logic [N-1:0] pa, input logic [N-1:0] pb,
                                             input logic mover_a);
        int  added;
        bit  erased, wrong, overlap;
        added = 0; erased = 0; wrong = 0; overlap = 0;
        for (int i = 0; i < N; i++) begin
            if ((ca[i] && !pa[i]) || (cb[i] && !pb[i])) erased = 1;
            if (pa[i] && !ca[i]) begin added++; if (!mover_a) wrong = 1; end
            if (pb[i] && !cb[i]) begin added++; if (mover_a) wrong = 1; end
            if (pa[i] && pb[i]) overlap = 1;
        end
        if (erased)          return 2'b01;
        if (added != 1)      return 2'b10;
        if (wrong || overlap) return 2'b11;
        return 2'b00;
    endfunction

    function automatic int pick_cell(input logic [N-1:0] mask, input logic want);
        int idx;
        for (int t = 0; t < 200; t++) begin
            idx = $urandom_range(0, N - 1);
            if (mask[idx] == want) return idx;
        end
        return -1;
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, ".board_a"}, board_a, m_a);
        chk({tag, ".board_b"}, board_b, m_b);
        chk({tag, ".turn_a"}, turn_a, m_turn);
        chk({tag, ".game_over"}, game_over, m_over);
        chk({tag, ".winner"}, winner, m_win);
        chk({tag, ".timeout"}, timeout, 0);
    endtask

    task automatic do_start(input logic l);
        local_is_a = l;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_a = '0; m_b = '0; m_turn = 1'b1; m_local = l; m_over = 1'b0; m_win = 2'b00; m_cnt = 0;
        chk_state("start");
        chk("start.judge_req", judge_req, 0);
        chk("start.loc_ready", loc_ready, (m_turn == m_local));
        chk("start.rem_ready", rem_ready, (m_turn != m_local));
    endtask

    // One proposal from the current mover; the non-mover drives junk that must be ignored.
    task automatic propose(input logic [N-1:0] pa, input logic [N-1:0] pb,
                           input logic je, input logic wa, input logic wb);
        logic       mloc;
        logic [1:0] e;
        mloc = (m_turn == m_local);
        e = model_err(m_a, m_b, pa, pb, m_turn);
        chk("wait.loc_ready", loc_ready, mloc);
        chk("wait.rem_ready", rem_ready, !mloc);
        if (mloc) begin
            loc_valid = 1'b1; loc_board_a = pa; loc_board_b = pb;
            rem_valid = 1'($urandom_range(0, 1));
            rem_board_a = N'($urandom); rem_board_b = N'($urandom);
        end else begin
            rem_valid = 1'b1; rem_board_a = pa; rem_board_b = pb;
            loc_valid = 1'($urandom_range(0, 1));
            loc_board_a = N'($urandom); loc_board_b = N'($urandom);
        end
        tick();
        loc_valid = 1'b0;
        rem_valid = 1'b0;
        chk("check.readies", {loc_ready, rem_ready}, 2'b00);
        chk("check.move_error", move_error, 0);
        tick();
        if (e != 2'b00) begin
            m_errc = e;
            chk("rej.move_error", move_error, 1);
            chk("rej.err_code", err_code, e);
            chk("rej.judge_req", judge_req, 0);
            chk_state("rej");
            chk("rej.mover_ready", mloc ? loc_ready : rem_ready, 1);
        end else begin
            m_a = pa; m_b = pb; m_cnt++;
            chk("acc.move_error", move_error, 0);
            chk("acc.err_code", err_code, m_errc);
            chk("acc.judge_req", judge_req, 1);
            chk_state("acc");
            repeat ($urandom_range(0, 2)) begin
                judge_end = 1'($urandom_range(0, 1));
                tick();
                chk("judge.hold", judge_req, 1);
            end
            judge_ready = 1'b1; judge_end = je; judge_win_a = wa; judge_win_b = wb;
            tick();
            judge_ready = 1'b0; judge_end = 1'b0; judge_win_a = 1'b0; judge_win_b = 1'b0;
            if (je) begin
                m_over = 1'b1; m_win = {wb, wa};
            end else if (m_cnt == N) begin
                m_over = 1'b1; m_win = 2'b00;
            end else begin
                m_turn = !m_turn;
            end
            chk("judge.req_drop", judge_req, 0);
            chk_state("judge");
        end
    endtask

    task automatic valid_move(output logic [N-1:0] pa, output logic [N-1:0] pb);
        int c;
        pa = m_a; pb = m_b;
        c = pick_cell(m_a | m_b, 1'b0);
        if (c >= 0) begin
            if (m_turn) pa[c] = 1'b1; else pb[c] = 1'b1;
        end
    endtask

    task automatic random_game();
        logic [N-1:0] pa, pb;
        logic         je, wa, wb;
        int           kind, c, sel, guard;
        do_start(1'($urandom_range(0, 1)));
        guard = 0;
        while (!m_over && guard < 60) begin
            guard++;
            valid_move(pa, pb);
            kind = $urandom_range(0, 9);
            case (kind)
                6: begin
                    c = pick_cell(m_a | m_b, 1'b1);
                    if (c >= 0) begin pa[c] = 1'b0; pb[c] = 1'b0; end
                end
                7: begin
                    c = pick_cell(pa | pb, 1'b0);
                    if (c >= 0) begin if (m_turn) pa[c] = 1'b1; else pb[c] = 1'b1; end
                end
                8: begin
                    pa = m_a; pb = m_b;
                    c = pick_cell(m_a | m_b, 1'b0);
                    if (c >= 0) begin if (m_turn) pb[c] = 1'b1; else pa[c] = 1'b1; end
                end
                9: begin
                    pa = m_a; pb = m_b;
                    c = pick_cell(m_turn ? m_b : m_a, 1'b1);
                    if (c >= 0) begin if (m_turn) pa[c] = 1'b1; else pb[c] = 1'b1; end
                end
                default: ;
            endcase
            je = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 2);
            wa = (sel == 1); wb = (sel == 2);
            propose(pa, pb, je, wa, wb);
        end
        chk("game.finished", m_over, 1);
        loc_valid = 1'b1; rem_valid = 1'b1;
        loc_board_a = N'($urandom); rem_board_b = N'($urandom);
        repeat (3) tick();
        loc_valid = 1'b0; rem_valid = 1'b0;
        chk("done.readies", {loc_ready, rem_ready}, 2'b00);
        chk_state("done");
    endtask

    initial begin
        logic [N-1:0] pa, pb;
        m_errc = 2'b00;
        m_a = '0; m_b = '0; m_turn = 1'b1; m_local = 1'b0; m_over = 1'b0; m_win = 2'b00; m_cnt = 0;

        repeat (3) tick();
        chk_state("reset");
        chk("reset.readies", {loc_ready, rem_ready}, 2'b00);
        chk("reset.judge_req", judge_req, 0);
        chk("reset.move_error", move_error, 0);
        chk("reset.err_code", err_code, 0);
        reset = 1'b1;
        tick();
        chk("idle.readies", {loc_ready, rem_ready}, 2'b00);

        // Opening move, then remote rejections of each kind, then a legal reply.
        do_start(1'b1);
        propose(9'h001, 9'h000, 1'b0, 1'b0, 1'b0);
        chk("open.rem_ready", rem_ready, 1);
        propose(9'h001, 9'h003, 1'b0, 1'b0, 1'b0);
        propose(9'h000, 9'h002, 1'b0, 1'b0, 1'b0);
        propose(9'h003, 9'h000, 1'b0, 1'b0, 1'b0);
        propose(9'h001, 9'h002, 1'b0, 1'b0, 1'b0);

        // Full draw: nine legal moves with no judge ending.
        do_start(1'b0);
        repeat (N) begin
            valid_move(pa, pb);
            propose(pa, pb, 1'b0, 1'b0, 1'b0);
        end
        chk("draw.game_over", game_over, 1);
        chk("draw.winner", winner, 2'b00);

        // A wins on its third move.
        do_start(1'b1);
        repeat (4) begin
            valid_move(pa, pb);
            propose(pa, pb, 1'b0, 1'b0, 1'b0);
        end
        valid_move(pa, pb);
        propose(pa, pb, 1'b1, 1'b1, 1'b0);
        chk("win.winner", winner, 2'b01);

        // Remote goes silent after the local opening move.
        do_start(1'b1);
        valid_move(pa, pb);
        propose(pa, pb, 1'b0, 1'b0, 1'b0);
`ifdef MOVE_TIMEOUT_EN
        repeat (TO - 1) begin
            tick();
            chk("to.early", timeout, 0);
        end
        tick();
        chk("to.pulse", timeout, 1);
        chk("to.game_over", game_over, 1);
        chk("to.winner", winner, 2'b01);
        tick();
        chk("to.pulse_end", timeout, 0);
        chk("to.hold", game_over, 1);
`else
        repeat (3 * TO) begin
            tick();
            chk("to.never", timeout, 0);
        end
        chk("to.still_waiting", rem_ready, 1);
`endif

        // start while JUDGE is pending.
        do_start(1'b1);
        valid_move(pa, pb);
        loc_valid = 1'b1; loc_board_a = pa; loc_board_b = pb;
        tick();
        loc_valid = 1'b0;
        tick();
        chk("abort.in_judge", judge_req, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        m_a = '0; m_b = '0; m_turn = 1'b1; m_over = 1'b0; m_win = 2'b00; m_cnt = 0;
        chk("abort.judge_req", judge_req, 0);
        chk_state("abort");
        chk("abort.loc_ready", loc_ready, 1);

        // reset while CHECK is evaluating, with start held to show reset wins.
        repeat (2) begin
            valid_move(pa, pb);
            propose(pa, pb, 1'b0, 1'b0, 1'b0);
        end
        valid_move(pa, pb);
        loc_valid = 1'b1; rem_valid = 1'b1;
        loc_board_a = pa; loc_board_b = pb; rem_board_a = pa; rem_board_b = pb;
        tick();
        loc_valid = 1'b0; rem_valid = 1'b0;
        reset = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        m_a = '0; m_b = '0; m_turn = 1'b1; m_over = 1'b0; m_win = 2'b00; m_cnt = 0; m_errc = 2'b00;
        chk_state("rst_check");
        chk("rst_check.judge_req", judge_req, 0);
        chk("rst_check.move_error", move_error, 0);
        reset = 1'b1;
        tick();
        chk("rst_check.idle", {loc_ready, rem_ready}, 2'b00);

        repeat (25) random_game();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/board_commit_arbiter.md
BOARD_COMMIT_ARBITER -- requirements
Module: board_commit_arbiter

Interface
REQ-001 Parameters SHALL be: ROWS, default 3, board rows; COLS, default 3, board columns; TIMEOUT_CYCLES, default 1000000, remote-move timeout; N = ROWS*COLS, cell index r*COLS+c.
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 start  in  1  one-cycle pulse: clear board, begin game with A to move.
REQ-005 local_is_a  in  1  local player owns plane A; sampled only on start.
REQ-006 loc_valid / loc_ready  in / out  1 / 1  local proposal handshake.
REQ-007 loc_board_a, loc_board_b  in  N each  local proposed full board.
REQ-008 rem_valid / rem_ready  in / out  1 / 1  remote proposal handshake.
REQ-009 rem_board_a, rem_board_b  in  N each  remote proposed full board.
REQ-010 board_a, board_b  out  N each  committed board.
REQ-011 judge_req / judge_ready  out / in  1 / 1  judge handshake.
REQ-012 judge_end, judge_win_a, judge_win_b  in  1 each  judge result, valid when judge_req && judge_ready.
REQ-013 turn_a  out  1  A to move.
REQ-014 move_error  out  1  one-cycle pulse on a rejected proposal.
REQ-015 err_code  out  2  01 cell erased/changed, 10 new-cell count != 1, 11 wrong plane or A/B overlap; holds until the next rejection.
REQ-016 game_over  out  1  level, game finished.
REQ-017 winner  out  2  00 draw/none, 01 A, 10 B.
REQ-018 timeout  out  1  one-cycle pulse on remote timeout.

Function
REQ-019 FSM states SHALL be IDLE, WAIT_MOVE, CHECK, JUDGE, DONE.
REQ-020 start in any state SHALL clear board, set turn_a=1, move count=0, game_over=0, winner=00, and go to WAIT_MOVE next cycle; this aborts any game in progress.
REQ-021 Mover source SHALL be local iff turn_a == local_is_a. In WAIT_MOVE only that source's ready=1; the other ready=0 and its valid is ignored.
REQ-022 Transfer on valid && ready; the proposal is latched; the FSM goes to CHECK (ready=0 from the next cycle).
REQ-023 CHECK (1 cycle) accepts iff the committed board is a subset of the proposal in both planes, exactly one new bit exists in total, that bit lies in the mover's plane, and (proposal_a & proposal_b) == 0. Checks are prioritized 01 > 10 > 11.
REQ-024 On reject, move_error=1 for one cycle, the board is unchanged, and the FSM returns to WAIT_MOVE with the same mover.
REQ-025 On accept, the board is committed at the end of CHECK, the move count increments, and the FSM goes to JUDGE.
REQ-026 In JUDGE, judge_req stays high until sampled with judge_ready=1. Then: judge_end=1 -> DONE with winner={judge_win_b, judge_win_a}. Otherwise, move count == N -> DONE with winner=00. Otherwise, toggle turn_a and go to WAIT_MOVE.
REQ-027 DONE holds game_over=1 and ignores proposals; only start or reset leaves it.
REQ-028 move_error and timeout SHALL never be asserted in the same cycle.

Reset
REQ-029 Reset low SHALL force: IDLE, board_a=board_b=0, turn_a=1, loc_ready=rem_ready=0, judge_req=0, move_error=0, err_code=00, game_over=0, winner=00, timeout=0, move count=0, timeout counter=0.
REQ-030 Reset SHALL override start in the same cycle.

Configuration
REQ-031 With MOVE_TIMEOUT_EN defined, a counter runs while in WAIT_MOVE with the remote mover and clears on leaving that state. When it reaches TIMEOUT_CYCLES-1: timeout pulses, FSM goes to DONE, winner = local player.
REQ-032 Without MOVE_TIMEOUT_EN, no counter is built and timeout is tied 0.

Structure
REQ-033 Package tictactoe_pkg SHALL hold the FSM state enum, the err_code enum and the winner encoding.
REQ-034 Combinational validation SHALL live in sub-module board_move_checker (inputs: committed board, proposal, mover plane; outputs: ok, err_code).

Verification
REQ-035 Reset, start, local_is_a=1, loc proposal a=0x001 -> loc_ready=1 before transfer; board_a=0x001 committed; judge_req until judge_ready; turn_a=0; rem_ready=1.
REQ-036 Remote proposes b=0x003 on an empty B plane (two new bits) -> move_error pulse, err_code=10, board unchanged, rem_ready=1 again.
REQ-037 Proposal erasing committed cell a=0x001 -> err_code=01. Proposal with new bit in the wrong plane -> err_code=11.
REQ-038 Nine valid alternating moves with judge_end=0 -> game_over=1, winner=00. A win with judge_end=1, judge_win_a=1 -> winner=01.
REQ-039 MOVE_TIMEOUT_EN, TIMEOUT_CYCLES=16, remote silent -> timeout pulse 16 cycles after entering WAIT_MOVE, winner=local. Without the macro -> no timeout.
REQ-040 start mid-JUDGE, and reset mid-CHECK -> board cleared, turn_a=1, no judge_req.
